// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared register-space constants and bypass select encoding.
//   REG_AW   - register address width used by decode, regfile and scoreboard
//   NREG     - architectural registers (integer and float share one space)
//   ZERO_REG - hardwired-zero register, never tracked
//   fwd_t    - operand source: register file or writeback bus
package sb_pkg;
    localparam int REG_AW   = 6;
    localparam int NREG     = 64;
    localparam int ZERO_REG = 0;
    typedef enum logic {FWD_RF, FWD_WB} fwd_t;
endpackage

// File: rtl/sb_src_check.sv
// sb_src_check: per-source RAW hazard and bypass detection against pending writes.
//   pending   - in, pending-write bit per register
//   wb_valid  - in, writeback bus carries a result
//   wb_rd     - in, writeback destination
//   src_valid - in, this source is read by the decode instruction
//   src_addr  - in, this source's register address
//   hazard    - out, source is pending and not being written back this cycle
//   fwd       - out, FWD_WB when the operand must come from the writeback bus
module sb_src_check
    import sb_pkg::*;
#(
    parameter int NREG_P   = NREG,
    parameter int AW       = REG_AW,
    parameter int ZERO_IDX = ZERO_REG
) (
    input  logic [NREG_P-1:0] pending,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic              src_valid,
    input  logic [AW-1:0]     src_addr,
    output logic              hazard,
    output fwd_t              fwd
);
    logic hit;
    logic wb_match;
    assign hit      = src_valid && src_addr != AW'(ZERO_IDX) && pending[src_addr];
    assign wb_match = wb_valid && wb_rd == src_addr;
    assign hazard   = hit && !wb_match;
    assign fwd      = (hit && wb_match) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending tracker producing decode stall and bypass selects.
//   clk, rst     - clock; asynchronous active-high reset
//   src_valid    - in, NSRC source-read flags of the decode instruction
//   src_addr     - in, NSRC packed source addresses, source i at [i*AW +: AW]
//   issue_valid  - in, decode instruction wants to move to exec
//   issue_we     - in, that instruction writes a register
//   issue_rd     - in, its destination
//   wb_valid     - in, writeback bus carries a result
//   wb_rd        - in, writeback destination
//   stall        - out, combinational decode hold request
//   fwd_sel      - out, combinational per-source take-from-writeback select
//   inflight     - out, registered count of outstanding writes
//   pending      - out, registered pending bit per register
//   sb_err       - out, sticky flag for a writeback to a non-pending register
module hazard_scoreboard
    import sb_pkg::*;
#(
    parameter int NREG_P       = NREG,
    parameter int AW           = REG_AW,
    parameter int NSRC         = 3,
    parameter int MAX_INFLIGHT = 8,
    parameter int ZERO_IDX     = ZERO_REG,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSRC-1:0]     src_valid,
    input  logic [NSRC*AW-1:0]  src_addr,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic [AW-1:0]       issue_rd,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    output logic                stall,
    output logic [NSRC-1:0]     fwd_sel,
    output logic [CW-1:0]       inflight,
    output logic [NREG_P-1:0]   pending,
    output logic                sb_err
);
    logic [NSRC-1:0] raw;
    fwd_t            fwd [NSRC];
    logic            wb_hit;
    logic            waw;
    logic            full;
    logic            fire;

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            sb_src_check #(.NREG_P(NREG_P), .AW(AW), .ZERO_IDX(ZERO_IDX)) u_chk (
                .pending  (pending),
                .wb_valid (wb_valid),
                .wb_rd    (wb_rd),
                .src_valid(src_valid[i]),
                .src_addr (src_addr[i*AW +: AW]),
                .hazard   (raw[i]),
                .fwd      (fwd[i])
            );
            assign fwd_sel[i] = fwd[i] == FWD_WB;
        end
    endgenerate

    // ZERO_REG is never pending, so a writeback to it can never count as a hit
    assign wb_hit = wb_valid && pending[wb_rd];
    // a same-cycle writeback to rd retires the older write, so the new one may issue
    assign waw    = issue_we && issue_rd != AW'(ZERO_IDX) && pending[issue_rd]
                    && !(wb_hit && wb_rd == issue_rd);
    // any writeback releases the full condition, even one that turns out erroneous
    assign full   = issue_we && inflight == CW'(MAX_INFLIGHT) && !wb_valid;
    assign stall  = issue_valid && (|raw || waw || full);
    assign fire   = issue_valid && !stall && issue_we && issue_rd != AW'(ZERO_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            inflight <= '0;
            sb_err   <= 1'b0;
        end else begin
            // clear before set so a same-register fire keeps the bit high
            pending  <= (pending & ~(NREG_P'(wb_hit) << wb_rd)) | (NREG_P'(fire) << issue_rd);
            inflight <= inflight + CW'(fire) - CW'(wb_hit);
            sb_err   <= sb_err | (wb_valid && wb_rd != AW'(ZERO_IDX) && !pending[wb_rd]);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus checked every cycle against a register-set model plus literal expectations.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_valid;
    logic [17:0] src_addr;
    logic        issue_valid;
    logic        issue_we;
    logic [5:0]  issue_rd;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic        stall;
    logic [2:0]  fwd_sel;
    logic [3:0]  inflight;
    logic [63:0] pending;
    logic        sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    // model: set of registers with an outstanding write, its size, and the error flag
    bit m_pend [64];
    int m_cnt;
    bit m_err;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_addr   (src_addr),
        .issue_valid(issue_valid),
        .issue_we   (issue_we),
        .issue_rd   (issue_rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .stall      (stall),
        .fwd_sel    (fwd_sel),
        .inflight   (inflight),
        .pending    (pending),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_cnt = 0;
        m_err = 0;
    endfunction

    // an operand is blocked if its register awaits a write that is not arriving right now
    function automatic bit blocked(input int r);
        return r != 0 && m_pend[r] && !(wb_valid && int'(wb_rd) == r);
    endfunction

    function automatic bit exp_stall();
        bit s = 0;
        for (int k = 0; k < 3; k++)
            if (src_valid[k] && blocked(int'(src_addr[k*6 +: 6]))) s = 1;
        if (issue_we && blocked(int'(issue_rd))) s = 1;
        if (issue_we && m_cnt == 8 && !wb_valid) s = 1;
        return issue_valid && s;
    endfunction

    function automatic logic [2:0] exp_fwd();
        logic [2:0] f = '0;
        for (int k = 0; k < 3; k++) begin
            int r = int'(src_addr[k*6 +: 6]);
            f[k] = src_valid[k] && r != 0 && m_pend[r] && wb_valid && int'(wb_rd) == r;
        end
        return f;
    endfunction

    function automatic logic [63:0] exp_pend_vec();
        logic [63:0] v = '0;
        foreach (m_pend[r]) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic model_check();
        chk("stall", stall, exp_stall());
        chk("fwd_sel", fwd_sel, exp_fwd());
        chk("inflight", inflight, m_cnt);
        chk("pending", pending, exp_pend_vec());
        chk("sb_err", sb_err, m_err);
    endtask

    task automatic model_step();
        bit s = exp_stall();
        int w = int'(wb_rd);
        int d = int'(issue_rd);
        bit hit = wb_valid && m_pend[w];
        bit fire = issue_valid && !s && issue_we && d != 0;
        if (rst) begin
            model_clear();
            return;
        end
        if (wb_valid && w != 0 && !m_pend[w]) m_err = 1;
        if (hit) m_pend[w] = 0;
        if (fire) m_pend[d] = 1;
        m_cnt += int'(fire) - int'(hit);
    endtask

    // one cycle: retire the previous cycle into the model, drive new inputs, check mid-cycle
    task automatic cyc(input logic [2:0] sv, input int a0, input int a1, input int a2,
                       input logic iv, input logic iwe, input int ird,
                       input logic wv, input int wrd);
        @(posedge clk);
        model_step();
        #1;
        src_valid   = sv;
        src_addr    = {6'(a2), 6'(a1), 6'(a0)};
        issue_valid = iv;
        issue_we    = iwe;
        issue_rd    = 6'(ird);
        wb_valid    = wv;
        wb_rd       = 6'(wrd);
        @(negedge clk);
        model_check();
    endtask

    task automatic idle();
        cyc(3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input int rd);
        cyc(3'b000, 0, 0, 0, 1, 1, rd, 0, 0);
    endtask

    task automatic wb(input int rd);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, 1, rd);
    endtask

    initial begin
        rst = 1'b1;
        src_valid = '0; src_addr = '0; issue_valid = 0; issue_we = 0; issue_rd = '0;
        wb_valid = 0; wb_rd = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_pending", pending, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", sb_err, 0);
        rst = 1'b0;

        issue(5);
        chk("issue5_stall", stall, 0);
        idle();
        chk("issue5_pend", pending[5], 1);
        chk("issue5_cnt", inflight, 1);

        cyc(3'b001, 5, 0, 0, 1, 0, 0, 0, 0);
        chk("raw_stall1", stall, 1);
        cyc(3'b001, 5, 0, 0, 1, 0, 0, 0, 0);
        chk("raw_stall2", stall, 1);
        cyc(3'b001, 5, 0, 0, 1, 0, 0, 1, 5);
        chk("raw_wb_stall", stall, 0);
        chk("raw_wb_fwd", fwd_sel, 3'b001);
        idle();
        chk("raw_clear", pending[5], 0);
        chk("raw_cnt", inflight, 0);

        issue(33);
        cyc(3'b000, 0, 0, 0, 1, 1, 33, 0, 0);
        chk("waw_stall", stall, 1);
        cyc(3'b000, 0, 0, 0, 1, 1, 33, 1, 33);
        chk("waw_wb_stall", stall, 0);
        idle();
        chk("waw_pend", pending[33], 1);
        chk("waw_cnt", inflight, 1);
        wb(33);
        idle();
        chk("waw_drain", inflight, 0);

        issue(40);
        issue(41);
        cyc(3'b111, 40, 41, 7, 1, 0, 0, 1, 41);
        chk("multi_stall", stall, 1);
        chk("multi_fwd", fwd_sel, 3'b010);
        cyc(3'b111, 40, 41, 7, 1, 0, 0, 1, 40);
        chk("multi_stall2", stall, 0);
        chk("multi_fwd2", fwd_sel, 3'b001);
        idle();

        for (int r = 1; r <= 8; r++) issue(r);
        idle();
        chk("fill_cnt", inflight, 8);
        cyc(3'b000, 0, 0, 0, 1, 1, 9, 0, 0);
        chk("full_stall", stall, 1);
        cyc(3'b000, 0, 0, 0, 1, 1, 9, 1, 1);
        chk("full_wb_stall", stall, 0);
        idle();
        chk("full_cnt", inflight, 8);
        chk("full_pend9", pending[9], 1);
        chk("full_pend1", pending[1], 0);
        for (int r = 2; r <= 9; r++) wb(r);
        idle();
        chk("drain_cnt", inflight, 0);

        issue(0);
        idle();
        chk("zero_pend", pending[0], 0);
        chk("zero_cnt", inflight, 0);
        wb(0);
        idle();
        chk("zero_wb_err", sb_err, 0);
        wb(12);
        idle();
        chk("err_set", sb_err, 1);
        idle();
        idle();
        chk("err_sticky", sb_err, 1);

        for (int r = 20; r <= 23; r++) issue(r);
        cyc(3'b001, 20, 0, 0, 1, 0, 0, 0, 0);
        chk("pre_rst_cnt", inflight, 4);
        chk("pre_rst_stall", stall, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pending", pending, 0);
        chk("arst_cnt", inflight, 0);
        chk("arst_stall", stall, 0);
        chk("arst_err", sb_err, 0);
        model_clear();
        idle();
        rst = 1'b0;
        issue(6);
        idle();
        chk("post_rst_cnt", inflight, 1);
        wb(6);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
